greater_flag: RTL and testbench

Magnitude comparator that raises a flag when input_a is strictly greater than input_b. It serves as the "greater" flag generator in the processor flag unit, alongside the equal flag, and feeds branch resolution (BGT/BGTU-style decisions). The comparison is unsigned by default, with a signed mode selectable per operation. The result is registered, so the flag has one cycle of latency.

---
 rtl/greater_flag_pkg.sv | 15 +
 rtl/greater_slice.sv | 17 +
 rtl/greater_flag.sv | 75 +++++++
 tb/tb_greater_flag.sv | 162 ++++++++++++++++
 4 files changed

// File: rtl/greater_flag_pkg.sv
// rtl/greater_flag_pkg.sv - shared definitions for the flag unit comparators
//   DEFAULT_WORDSIZE : default operand width in bits
//   SLICE_W          : width of one compare slice
//   slice_res_t      : {gt, eq} result of one slice compare
package greater_flag_pkg;

    localparam int DEFAULT_WORDSIZE = 64;
    localparam int SLICE_W          = 8;

    typedef struct packed {
        logic gt;
        logic eq;
    } slice_res_t;

endpackage

// File: rtl/greater_slice.sv
// rtl/greater_slice.sv - one-byte magnitude compare producing {gt, eq}
//   a, b : SLICE_W-bit operands (unsigned)
//   res  : res.gt = a > b, res.eq = a == b
module greater_slice
    import greater_flag_pkg::*;
(
    input  logic [SLICE_W-1:0] a,
    input  logic [SLICE_W-1:0] b,
    output slice_res_t         res
);

    always_comb begin
        res.gt = (a > b);
        res.eq = (a == b);
    end

endmodule

// File: rtl/greater_flag.sv
// rtl/greater_flag.sv - registered a > b flag, unsigned or signed per operation
//   clk, rst_n         : clock, asynchronous active-low reset
//   in_valid           : operands and mode valid this cycle
//   is_signed          : 1 = two's-complement compare, 0 = unsigned
//   input_a, input_b   : WORDSIZE-bit operands
//   greater, out_valid : registered result, one cycle after in_valid
module greater_flag
    import greater_flag_pkg::*;
#(
    parameter int WORDSIZE = DEFAULT_WORDSIZE
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                in_valid,
    input  logic                is_signed,
    input  logic [WORDSIZE-1:0] input_a,
    input  logic [WORDSIZE-1:0] input_b,
    output logic                greater,
    output logic                out_valid
);

    localparam int NSL = WORDSIZE / SLICE_W;

    // Flipping the sign bit maps two's-complement order onto unsigned order,
    // so the same slice chain serves both modes.
    logic [WORDSIZE-1:0] a_adj;
    logic [WORDSIZE-1:0] b_adj;

    always_comb begin
        a_adj = input_a;
        b_adj = input_b;
        a_adj[WORDSIZE-1] = input_a[WORDSIZE-1] ^ is_signed;
        b_adj[WORDSIZE-1] = input_b[WORDSIZE-1] ^ is_signed;
    end

    slice_res_t res [NSL];

    for (genvar g = 0; g < NSL; g++) begin : g_slice
        greater_slice u_slice (
            .a   (a_adj[g*SLICE_W +: SLICE_W]),
            .b   (b_adj[g*SLICE_W +: SLICE_W]),
            .res (res[g])
        );
    end

    // Priority merge: the most significant unequal slice decides.
    // All slices equal leaves gt_comb at 0, keeping the compare strict.
    logic gt_comb;
    logic decided;

    always_comb begin
        gt_comb = 1'b0;
        decided = 1'b0;
        for (int i = NSL - 1; i >= 0; i--) begin
            if (!decided && !res[i].eq) begin
                gt_comb = res[i].gt;
                decided = 1'b1;
            end
        end
    end

    // greater holds across in_valid gaps; only out_valid drops.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            greater   <= 1'b0;
            out_valid <= 1'b0;
        end else begin
            out_valid <= in_valid;
            if (in_valid) begin
                greater <= gt_comb;
            end
        end
    end

endmodule

// File: tb/tb_greater_flag.sv
// tb/tb_greater_flag.sv - self-checking bench for greater_flag
module tb_greater_flag;

    localparam int W = 64;

    logic         clk;
    logic         rst_n;
    logic         in_valid;
    logic         is_signed;
    logic [W-1:0] input_a;
    logic [W-1:0] input_b;
    logic         greater;
    logic         out_valid;

    int n_assert;
    int n_fail;

    logic exp_q [$];
    logic last_g;

    greater_flag #(.WORDSIZE(W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .is_signed (is_signed),
        .input_a   (input_a),
        .input_b   (input_b),
        .greater   (greater),
        .out_valid (out_valid)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic model(input logic s, input logic [W-1:0] a, input logic [W-1:0] b);
        if (s) return ($signed(a) > $signed(b));
        return (a > b);
    endfunction

    function automatic logic [W-1:0] rnd64();
        return {$urandom(), $urandom()};
    endfunction

    task automatic check(input string tag, input logic obs, input logic exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    // Drive one cycle at the falling edge, check the result just after the rising edge.
    task automatic drive(input string tag, input logic v, input logic s,
                         input logic [W-1:0] a, input logic [W-1:0] b);
        logic e;
        @(negedge clk);
        in_valid  = v;
        is_signed = s;
        input_a   = a;
        input_b   = b;
        if (v) exp_q.push_back(model(s, a, b));
        @(posedge clk);
        #1;
        check({tag, ".out_valid"}, out_valid, v);
        if (v) begin
            if (exp_q.size() == 0) begin
                check({tag, ".scoreboard_empty"}, 1'b1, 1'b0);
            end else begin
                e = exp_q.pop_front();
                check({tag, ".greater"}, greater, e);
                last_g = e;
            end
        end else begin
            check({tag, ".hold"}, greater, last_g);
        end
    endtask

    initial begin
        logic [W-1:0] a;
        logic [W-1:0] b;
        n_assert  = 0;
        n_fail    = 0;
        last_g    = 1'b0;
        rst_n     = 1'b0;
        in_valid  = 1'b1;
        is_signed = 1'b0;
        input_a   = '0;
        input_b   = '0;

        // Reset held with live random inputs
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            input_a   = rnd64();
            input_b   = rnd64();
            is_signed = 1'(i);
            @(posedge clk);
            #1;
            check("rst.greater", greater, 1'b0);
            check("rst.out_valid", out_valid, 1'b0);
        end
        @(negedge clk);
        rst_n    = 1'b1;
        in_valid = 1'b0;

        // Unsigned basics
        drive("u_5_2", 1, 0, 64'h5, 64'h2);
        drive("u_5_5", 1, 0, 64'h5, 64'h5);
        drive("u_1_big", 1, 0, 64'h1, 64'h1000_0000_0000_0001);
        drive("u_1_5", 1, 0, 64'h1, 64'h5);

        // Sign mode
        drive("u_min_1", 1, 0, 64'h8000_0000_0000_0000, 64'h1);
        drive("s_min_1", 1, 1, 64'h8000_0000_0000_0000, 64'h1);
        drive("u_ones_0", 1, 0, '1, '0);
        drive("s_ones_0", 1, 1, '1, '0);
        drive("u_80_7f", 1, 0, 64'h8000_0000_0000_0000, 64'h7FFF_FFFF_FFFF_FFFF);
        drive("s_80_7f", 1, 1, 64'h8000_0000_0000_0000, 64'h7FFF_FFFF_FFFF_FFFF);
        drive("u_0_0", 1, 0, '0, '0);
        drive("s_0_0", 1, 1, '0, '0);
        drive("s_eq_neg", 1, 1, 64'hFFFF_FFFF_FFFF_FFF0, 64'hFFFF_FFFF_FFFF_FFF0);

        // Byte-boundary decisions
        drive("lowbyte", 1, 0, 64'h1234_5678_9ABC_DE01, 64'h1234_5678_9ABC_DE00);
        drive("topbyte", 1, 0, 64'h1300_0000_0000_0000, 64'h12FF_FFFF_FFFF_FFFF);
        drive("midbyte_lt", 1, 0, 64'h1234_0000_0000_00FF, 64'h1234_0100_0000_0000);

        // Valid gaps: greater holds, out_valid follows in_valid
        drive("gap_v1", 1, 0, 64'h9, 64'h3);
        drive("gap_v0a", 0, 0, 64'h0, 64'h9);
        drive("gap_v1b", 1, 1, 64'h3, 64'h9);
        drive("gap_v0b", 0, 0, 64'h9, 64'h0);
        drive("gap_v1c", 1, 1, 64'h7, 64'hFFFF_FFFF_FFFF_FFFF);

        // Asynchronous reset between edges
        drive("pre_rst", 1, 0, '1, 64'h1);
        #1;
        rst_n = 1'b0;
        #1;
        check("async_rst.greater", greater, 1'b0);
        check("async_rst.out_valid", out_valid, 1'b0);
        rst_n = 1'b1;
        exp_q.delete();
        last_g = 1'b0;
        drive("post_rst", 1, 0, 64'h2, 64'h1);

        // Back-to-back random stream, both modes
        for (int i = 0; i < 1000; i++) begin
            a = rnd64();
            case ($urandom_range(0, 3))
                0: b = a;
                1: b = {a[W-1:8], 8'($urandom())};
                2: b = {8'($urandom()), a[W-9:0]};
                default: b = rnd64();
            endcase
            drive("rand", 1, 1'($urandom_range(0, 1)), a, b);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
